wb_grf: RTL

//   Write-back stage consumer of the MEM/WB pipeline register outputs, plus the 32x32 general register file.
//   - Selects the write address and write data, then writes the GRF.
//   - Serves two D-stage read ports with W->D internal bypass.
//   - Exports the W-stage forwarding source to the hazard unit.
//   - Emits a registered write trace, a write counter and a sticky decode-error flag for debug.

---
 rtl/wb_grf.sv | 136 +++++++++++++
 1 files changed

// File: rtl/wb_grf.sv
// Write-back stage: selects the GRF write address/data from the MEM/WB
// register outputs, owns the 32x32 register file with W->D bypass, exports
// the W-stage forwarding source and keeps a small debug trace.
module wb_grf #(
   parameter int NREG   = 32,
   parameter int RA_IDX = 31
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  Tnew_i,
   input  logic [4:0]  A3_i,
   input  logic [31:0] ALUR_i,
   input  logic [31:0] MDUR_i,
   input  logic [31:0] PC4_i,
   input  logic [31:0] E32_i,
   input  logic [31:0] PC8_i,
   input  logic [31:0] DR_i,
   input  logic [31:0] CP0_RD_i,
   input  logic [3:0]  rf_wa_sel_i,
   input  logic [3:0]  rf_wd_sel_i,
   input  logic        rf_we_i,
   input  logic [4:0]  rs_addr_i,
   input  logic [4:0]  rt_addr_i,
   output logic [31:0] rs_data_o,
   output logic [31:0] rt_data_o,
   output logic        fwd_we_o,
   output logic [4:0]  fwd_addr_o,
   output logic [31:0] fwd_data_o,
   output logic        trace_vld_o,
   output logic [31:0] trace_pc_o,
   output logic [4:0]  trace_addr_o,
   output logic [31:0] trace_data_o,
   output logic [31:0] wr_cnt_o,
   output logic        sel_err_o
);

   logic [31:0] grf_q [NREG];
   logic [31:0] grf_d [NREG];

   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        wa_ok, wd_ok, weff, err_evt;

   logic        trace_vld_q, trace_vld_d;
   logic [31:0] trace_pc_q,  trace_pc_d;
   logic [4:0]  trace_addr_q, trace_addr_d;
   logic [31:0] trace_data_q, trace_data_d;
   logic [31:0] wr_cnt_q,    wr_cnt_d;
   logic        sel_err_q,   sel_err_d;

   // Decode write address/data and derive the effective write enable.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      waddr = '0;
      wa_ok = 1'b1;
      wdata = '0;
      wd_ok = 1'b1;
      case (rf_wa_sel_i)
         4'd0:    waddr = A3_i;
         4'd1:    waddr = 5'(RA_IDX);
         default: wa_ok = 1'b0;
      endcase
      case (rf_wd_sel_i)
         4'd0:    wdata = ALUR_i;
         4'd1:    wdata = DR_i;
         4'd2:    wdata = PC8_i;
         4'd3:    wdata = E32_i;
         4'd4:    wdata = MDUR_i;
         4'd5:    wdata = CP0_RD_i;
         4'd6:    wdata = PC4_i;
         default: wd_ok = 1'b0;
      endcase
      weff    = rf_we_i && (waddr != 5'd0) && wa_ok && wd_ok;
      err_evt = rf_we_i && (!(wa_ok && wd_ok) || (Tnew_i != 2'd0));
   end

   // Forwarding source and bypassed read ports.
   always_comb begin
      fwd_we_o   = weff;
      fwd_addr_o = weff ? waddr : 5'd0;
      fwd_data_o = wdata;
      rs_data_o  = (rs_addr_i == 5'd0) ? 32'd0
                 : (weff && rs_addr_i == waddr) ? wdata : grf_q[rs_addr_i];
      rt_data_o  = (rt_addr_i == 5'd0) ? 32'd0
                 : (weff && rt_addr_i == waddr) ? wdata : grf_q[rt_addr_i];
   end

   // Next-state for the register file and the debug registers.
   always_comb begin
      grf_d        = grf_q;
      trace_vld_d  = weff;
      trace_pc_d   = trace_pc_q;
      trace_addr_d = trace_addr_q;
      trace_data_d = trace_data_q;
      wr_cnt_d     = wr_cnt_q;
      sel_err_d    = sel_err_q | err_evt;
      if (weff) begin
         grf_d[waddr] = wdata;
         trace_pc_d   = PC4_i - 32'd4;
         trace_addr_d = waddr;
         trace_data_d = wdata;
         wr_cnt_d     = wr_cnt_q + 32'd1;
      end
   end

   // State registers, asynchronously cleared.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the GRF itself is cleared on reset because software expects zeroed registers.
         for (int i = 0; i < NREG; i++) grf_q[i] <= '0;
         trace_vld_q  <= 1'b0;
         trace_pc_q   <= '0;
         trace_addr_q <= '0;
         trace_data_q <= '0;
         wr_cnt_q     <= '0;
         sel_err_q    <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         grf_q        <= grf_d;
         trace_vld_q  <= trace_vld_d;
         trace_pc_q   <= trace_pc_d;
         trace_addr_q <= trace_addr_d;
         trace_data_q <= trace_data_d;
         wr_cnt_q     <= wr_cnt_d;
         sel_err_q    <= sel_err_d;
      end
   end

   assign trace_vld_o  = trace_vld_q;
   assign trace_pc_o   = trace_pc_q;
   assign trace_addr_o = trace_addr_q;
   assign trace_data_o = trace_data_q;
   assign wr_cnt_o     = wr_cnt_q;
   assign sel_err_o    = sel_err_q;

endmodule
